regfile_wb_sequencer: RTL and testbench

// - Write-side initiator for the 32x32 register file: collects results from ALU and LSU, arbitrates, drives
//   the file's write strobe, write address and write data ports.
// - Register file latches on the rising edge of its write strobe, so this block generates a clean

---
 rtl/rv32_wb_pkg.sv | 12 +
 rtl/wb_fifo.sv | 47 ++++
 rtl/regfile_wb_sequencer.sv | 119 +++++++++++
 tb/tb_regfile_wb_sequencer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_wb_pkg.sv
// Shared types for the register-file write-back path.
package rv32_wb_pkg;
    typedef logic [4:0]  reg_addr_t;
    typedef logic [31:0] word_t;

    typedef struct packed {
        reg_addr_t rd;
        word_t     data;
    } wb_entry_t;

    typedef enum logic [1:0] {WB_IDLE, WB_SETUP, WB_STROBE} wb_state_t;
endpackage

// File: rtl/wb_fifo.sv
// Small FIFO of write-back entries; push is ignored when full, pop when empty.
module wb_fifo import rv32_wb_pkg::*; #(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push_i,
    input  wb_entry_t push_data_i,
    input  logic      pop_i,
    output wb_entry_t head_o,
    output logic      full_o,
    output logic      empty_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wb_entry_t     mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, wr_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end
endmodule

// File: rtl/regfile_wb_sequencer.sv
// Arbitrates ALU/LSU results into setup-then-strobe register-file writes and
// tracks pending destinations for hazard detection.
module regfile_wb_sequencer import rv32_wb_pkg::*; #(
    parameter int FIFO_DEPTH = 2,
    parameter int MAX_WAIT   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_valid,
    input  reg_addr_t   alu_rd,
    input  word_t       alu_data,
    output logic        alu_ready,
    input  logic        lsu_valid,
    input  reg_addr_t   lsu_rd,
    input  word_t       lsu_data,
    output logic        lsu_ready,
    input  logic        issue_valid,
    input  reg_addr_t   issue_rd,
    output logic [31:0] busy_mask,
    output logic        rf_wr_en,
    output reg_addr_t   rf_wr_addr,
    output word_t       rf_wr_data
);
    localparam int WW = $clog2(MAX_WAIT + 1);

    wb_state_t   state_q, state_d;
    logic        wr_en_q, wr_en_d;
    reg_addr_t   addr_q, addr_d;
    word_t       data_q, data_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [31:0] busy_q, busy_d;

    wb_entry_t alu_head, lsu_head;
    logic      alu_full, alu_empty, lsu_full, lsu_empty;
    logic      alu_wr, lsu_wr, pop_pt, grant_alu, grant_lsu, alu_pop, lsu_pop;

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_alu_fifo (
        .clk(clk), .reset(reset),
        .push_i(alu_valid), .push_data_i('{rd: alu_rd, data: alu_data}),
        .pop_i(alu_pop), .head_o(alu_head), .full_o(alu_full), .empty_o(alu_empty)
    );

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_lsu_fifo (
        .clk(clk), .reset(reset),
        .push_i(lsu_valid), .push_data_i('{rd: lsu_rd, data: lsu_data}),
        .pop_i(lsu_pop), .head_o(lsu_head), .full_o(lsu_full), .empty_o(lsu_empty)
    );

    assign alu_ready = !alu_full;
    assign lsu_ready = !lsu_full;

    // Heads targeting x0 are discarded at pop points without taking a write slot.
    assign alu_wr    = !alu_empty && (alu_head.rd != '0);
    assign lsu_wr    = !lsu_empty && (lsu_head.rd != '0);
    assign pop_pt    = (state_q != WB_SETUP);
    assign grant_alu = pop_pt && alu_wr && (!lsu_wr || wait_q == WW'(MAX_WAIT));
    assign grant_lsu = pop_pt && lsu_wr && !grant_alu;
    assign alu_pop   = pop_pt && !alu_empty && ((alu_head.rd == '0) || grant_alu);
    assign lsu_pop   = pop_pt && !lsu_empty && ((lsu_head.rd == '0) || grant_lsu);

    always_comb begin
        state_d = state_q;
        wr_en_d = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        wait_d  = wait_q;
        case (state_q)
            WB_SETUP: begin
                state_d = WB_STROBE;
                wr_en_d = 1'b1;
            end
            WB_IDLE, WB_STROBE: begin
                if (grant_alu || grant_lsu) begin
                    state_d = WB_SETUP;
                    addr_d  = grant_alu ? alu_head.rd   : lsu_head.rd;
                    data_d  = grant_alu ? alu_head.data : lsu_head.data;
                end else begin
                    state_d = WB_IDLE;
                end
                if (!alu_wr || grant_alu)
                    wait_d = '0;
                else if (wait_q != WW'(MAX_WAIT))
                    wait_d = wait_q + 1'b1;
            end
            default: state_d = WB_IDLE;
        endcase
    end

    // A new issue to the register being retired this cycle keeps it busy.
    always_comb begin
        busy_d = busy_q;
        if (state_q == WB_STROBE) busy_d[addr_q] = 1'b0;
        if (issue_valid && issue_rd != '0) busy_d[issue_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= WB_IDLE;
            wr_en_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            wait_q  <= '0;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            wr_en_q <= wr_en_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wait_q  <= wait_d;
            busy_q  <= busy_d;
        end
    end

    assign busy_mask  = busy_q;
    assign rf_wr_en   = wr_en_q;
    assign rf_wr_addr = addr_q;
    assign rf_wr_data = data_q;
endmodule

// File: tb/tb_regfile_wb_sequencer.sv
// Directed bench for regfile_wb_sequencer with a queue-based reference model.
module tb_regfile_wb_sequencer;
    localparam int FIFO_DEPTH = 2;
    localparam int MAX_WAIT   = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        alu_valid = 1'b0, lsu_valid = 1'b0, issue_valid = 1'b0;
    logic [4:0]  alu_rd = '0, lsu_rd = '0, issue_rd = '0;
    logic [31:0] alu_data = '0, lsu_data = '0;
    logic        alu_ready, lsu_ready, rf_wr_en;
    logic [31:0] busy_mask, rf_wr_data;
    logic [4:0]  rf_wr_addr;

    always #5 clk = ~clk;

    regfile_wb_sequencer #(.FIFO_DEPTH(FIFO_DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .busy_mask(busy_mask),
        .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        alu_q[$], lsu_q[$], wlog[$], cur;
    int          slot = 0, starve = 0, cyc = 0;
    logic [31:0] m_busy = '0;
    bit          m_ar, m_lr, m_aw, m_lw, m_ua;
    int          total = 0, bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: slot 2 = address presented, slot 1 = strobe cycle, 0 = bus free.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_q.delete();
            lsu_q.delete();
            slot   = 0;
            starve = 0;
            m_busy = '0;
            cur    = '{5'd0, 32'd0};
        end else begin
            cyc++;
            m_ar = alu_q.size() < FIFO_DEPTH;
            m_lr = lsu_q.size() < FIFO_DEPTH;
            if (slot == 1) m_busy[cur.rd] = 1'b0;
            if (slot != 2) begin
                m_aw = alu_q.size() > 0 && alu_q[0].rd != 0;
                m_lw = lsu_q.size() > 0 && lsu_q[0].rd != 0;
                if (alu_q.size() > 0 && alu_q[0].rd == 0) void'(alu_q.pop_front());
                if (lsu_q.size() > 0 && lsu_q[0].rd == 0) void'(lsu_q.pop_front());
                if (m_aw || m_lw) begin
                    m_ua = m_aw && (!m_lw || starve == MAX_WAIT);
                    cur  = m_ua ? alu_q.pop_front() : lsu_q.pop_front();
                    if (!m_aw || m_ua) starve = 0;
                    else if (starve < MAX_WAIT) starve++;
                    slot = 2;
                end else begin
                    starve = 0;
                    slot   = 0;
                end
            end else begin
                slot = 1;
            end
            if (alu_valid && m_ar) alu_q.push_back('{alu_rd, alu_data});
            if (lsu_valid && m_lr) lsu_q.push_back('{lsu_rd, lsu_data});
            if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("alu_ready", 64'(alu_ready), 64'(alu_q.size() < FIFO_DEPTH));
            check("lsu_ready", 64'(lsu_ready), 64'(lsu_q.size() < FIFO_DEPTH));
            check("busy_mask", 64'(busy_mask), 64'(m_busy));
            check("rf_wr_en", 64'(rf_wr_en), 64'(slot == 1));
            if (slot != 0) begin
                check("rf_wr_addr", 64'(rf_wr_addr), 64'(cur.rd));
                check("rf_wr_data", 64'(rf_wr_data), 64'(cur.data));
            end
            if (rf_wr_en) wlog.push_back('{rf_wr_addr, rf_wr_data});
        end
    end

    task automatic settle();
        repeat (8) @(posedge clk);
        #1;
        wlog.delete();
    endtask

    task automatic wait_log(input int n, input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge clk);
            #1;
            if (wlog.size() >= n) ok = 1;
        end
    endtask

    task automatic wait_wr(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (rf_wr_en) ok = 1;
        end
    endtask

    task automatic issue(input logic [4:0] rd);
        issue_valid = 1'b1;
        issue_rd    = rd;
        @(posedge clk);
        #1;
        issue_valid = 1'b0;
    endtask

    initial begin
        bit ok;
        int t0, li, acc;
        logic [4:0] exp_rd [7];

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_wr_en", 64'(rf_wr_en), 64'd0);
        check("rst_addr", 64'(rf_wr_addr), 64'd0);
        check("rst_data", 64'(rf_wr_data), 64'd0);
        check("rst_busy", 64'(busy_mask), 64'd0);
        check("rst_alu_ready", 64'(alu_ready), 64'd1);
        check("rst_lsu_ready", 64'(lsu_ready), 64'd1);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single ALU write, latency and scoreboard clear
        issue(5'd5);
        check("t1_busy_set", 64'(busy_mask), 64'h20);
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        t0 = cyc;
        alu_valid = 1'b0;
        wait_wr(20, ok);
        check("t1_wr_seen", 64'(ok), 64'd1);
        check("t1_latency", 64'(cyc - t0), 64'd2);
        check("t1_addr", 64'(rf_wr_addr), 64'd5);
        check("t1_data", 64'(rf_wr_data), 64'hDEADBEEF);
        check("t1_busy_in_strobe", 64'(busy_mask[5]), 64'd1);
        @(posedge clk);
        #1;
        check("t1_busy_cleared", 64'(busy_mask), 64'd0);
        check("t1_wr_fell", 64'(rf_wr_en), 64'd0);
        settle();

        // Simultaneous push: LSU first
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
        lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h22;
        @(posedge clk);
        #1;
        alu_valid = 1'b0; lsu_valid = 1'b0;
        wait_log(2, 30, ok);
        check("t2_two_writes", 64'(ok), 64'd1);
        if (wlog.size() >= 2) begin
            check("t2_first_rd", 64'(wlog[0].rd), 64'd4);
            check("t2_first_data", 64'(wlog[0].data), 64'h22);
            check("t2_second_rd", 64'(wlog[1].rd), 64'd3);
            check("t2_second_data", 64'(wlog[1].data), 64'h11);
        end
        settle();

        // LSU stream with one ALU entry waiting
        exp_rd = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd20, 5'd14, 5'd15};
        alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'h200;
        li = 0;
        for (int k = 0; k < 60 && li < 6; k++) begin
            lsu_valid = 1'b1; lsu_rd = 5'(10 + li); lsu_data = 32'h100 + 32'(li);
            @(negedge clk);
            acc = int'(lsu_ready);
            @(posedge clk);
            #1;
            alu_valid = 1'b0;
            if (acc != 0) li++;
        end
        lsu_valid = 1'b0;
        wait_log(7, 40, ok);
        check("t3_seven_writes", 64'(ok), 64'd1);
        for (int i = 0; i < 7; i++)
            if (i < wlog.size()) check($sformatf("t3_order_%0d", i), 64'(wlog[i].rd), 64'(exp_rd[i]));
        settle();

        // x0 entry is discarded
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        alu_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("t4_no_write", 64'(wlog.size()), 64'd0);
        check("t4_busy", 64'(busy_mask), 64'd0);
        check("t4_alu_ready", 64'(alu_ready), 64'd1);
        settle();

        // Fill ALU FIFO; fourth offer lands while full and is dropped
        alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'hA0;
        @(posedge clk); #1;
        alu_rd = 5'd7; alu_data = 32'hA1;
        @(posedge clk); #1;
        alu_rd = 5'd8; alu_data = 32'hA2;
        @(posedge clk); #1;
        alu_rd = 5'd9; alu_data = 32'hA3;
        @(negedge clk);
        check("t5_full_not_ready", 64'(alu_ready), 64'd0);
        @(posedge clk); #1;
        alu_valid = 1'b0;
        check("t5_ready_back", 64'(alu_ready), 64'd1);
        wait_log(3, 30, ok);
        check("t5_three_writes", 64'(ok), 64'd1);
        repeat (8) @(posedge clk);
        #1;
        check("t5_no_extra", 64'(wlog.size()), 64'd3);
        if (wlog.size() >= 3) begin
            check("t5_rd0", 64'(wlog[0].rd), 64'd6);
            check("t5_rd1", 64'(wlog[1].rd), 64'd7);
            check("t5_rd2", 64'(wlog[2].rd), 64'd8);
            check("t5_data2", 64'(wlog[2].data), 64'hA2);
        end
        settle();

        // Reset during a strobe
        issue(5'd7);
        issue(5'd8);
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h77;
        alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 32'h88;
        @(posedge clk);
        #1;
        lsu_valid = 1'b0; alu_valid = 1'b0;
        wait_wr(20, ok);
        check("t6_strobe_seen", 64'(ok), 64'd1);
        #1;
        reset = 1'b1;
        #1;
        check("t6_wr_dropped", 64'(rf_wr_en), 64'd0);
        check("t6_busy_cleared", 64'(busy_mask), 64'd0);
        check("t6_addr_cleared", 64'(rf_wr_addr), 64'd0);
        check("t6_lsu_ready", 64'(lsu_ready), 64'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        wlog.delete();
        repeat (10) @(posedge clk);
        #1;
        check("t6_no_write_after", 64'(wlog.size()), 64'd0);
        check("t6_busy_after", 64'(busy_mask), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end
endmodule
